// File: rtl/lcd_hd44780_ctrl_if.sv
// Write-side handshake between the LSU LCD register decode and the LCD controller.
// The master pushes {rs, data} bytes; the slave (controller) reports FIFO space.
interface lcd_hd44780_ctrl_if;
   logic       i_wr_vld;
   logic       i_wr_rs;
   logic [7:0] i_wr_data;
   logic       o_wr_rdy;

   modport master (
      output i_wr_vld,
      output i_wr_rs,
      output i_wr_data,
      input  o_wr_rdy
   );

   modport slave (
      input  i_wr_vld,
      input  i_wr_rs,
      input  i_wr_data,
      output o_wr_rdy
   );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 LCD controller: power-up init sequence, then drains a 4-entry
// {rs, data} FIFO as timed bus writes (setup, EN pulse, hold, execution wait).
module lcd_hd44780_ctrl #(
   parameter int PWRUP_CYC = 750000,
   parameter int SETUP_CYC = 2,
   parameter int EN_CYC    = 12,
   parameter int HOLD_CYC  = 2,
   parameter int EXEC_CYC  = 2500,
   parameter int LONG_CYC  = 82000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_on,
   lcd_hd44780_ctrl_if.slave        wr,
   output logic                     o_busy,
   output logic                     o_init_done,
   output logic                     o_drop,
   output logic                     o_lcd_on,
   output logic                     o_lcd_en,
   output logic                     o_lcd_rs,
   output logic                     o_lcd_rw,
   output logic [7:0]               o_lcd_data
);

   localparam logic [19:0] PWRUP_LD = 20'(PWRUP_CYC);
   localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC);
   localparam logic [19:0] EN_LD    = 20'(EN_CYC);
   localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC);
   localparam logic [19:0] EXEC_LD  = 20'(EXEC_CYC);
   localparam logic [19:0] LONG_LD  = 20'(LONG_CYC);

   typedef enum logic [2:0] {PWRUP, IDLE, SETUP, EN_HI, HOLD, EXEC} state_t;

   state_t      state, state_n;
   logic [19:0] cnt, cnt_n;
   logic [2:0]  init_idx, init_idx_n;
   logic [8:0]  fifo_mem [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  fifo_cnt;
   logic        push, pop, load, cnt_last, long_wait;
   logic [8:0]  load_byte;

   function automatic logic [8:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0:    init_rom = 9'h038;
         3'd1:    init_rom = 9'h038;
         3'd2:    init_rom = 9'h00C;
         3'd3:    init_rom = 9'h001;
         3'd4:    init_rom = 9'h006;
         default: init_rom = 9'h000;
      endcase
   endfunction

   assign o_init_done = (init_idx == 3'd5);
   assign wr.o_wr_rdy = (fifo_cnt != 3'd4);
   assign push        = wr.i_wr_vld && wr.o_wr_rdy;
   assign o_busy      = (state != IDLE) || (fifo_cnt != 3'd0) || !o_init_done;
   assign o_lcd_rw    = 1'b0;
   assign cnt_last    = (cnt == 20'd1);
   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   assign long_wait   = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data != 8'd0);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      init_idx_n = init_idx;
      pop        = 1'b0;
      load       = 1'b0;
      load_byte  = 9'h000;
      case (state)
         PWRUP: begin
            if (cnt_last) begin
               state_n   = SETUP;
               cnt_n     = SETUP_LD;
               load      = 1'b1;
               load_byte = init_rom(3'd0);
            end else begin
               cnt_n = cnt - 20'd1;
            end
         end
         IDLE: begin
            if (o_init_done && (fifo_cnt != 3'd0)) begin
               pop       = 1'b1;
               load      = 1'b1;
               load_byte = fifo_mem[rd_ptr];
               state_n   = SETUP;
               cnt_n     = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_last) begin
               state_n = EN_HI;
               cnt_n   = EN_LD;
            end else begin
               cnt_n = cnt - 20'd1;
            end
         end
         EN_HI: begin
            if (cnt_last) begin
               state_n = HOLD;
               cnt_n   = HOLD_LD;
            end else begin
               cnt_n = cnt - 20'd1;
            end
         end
         HOLD: begin
            if (cnt_last) begin
               state_n = EXEC;
               cnt_n   = long_wait ? LONG_LD : EXEC_LD;
            end else begin
               cnt_n = cnt - 20'd1;
            end
         end
         EXEC: begin
            if (cnt_last) begin
               if (!o_init_done) begin
                  init_idx_n = init_idx + 3'd1;
                  if (init_idx == 3'd4) begin
                     state_n = IDLE;
                  end else begin
                     state_n   = SETUP;
                     cnt_n     = SETUP_LD;
                     load      = 1'b1;
                     load_byte = init_rom(init_idx + 3'd1);
                  end
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 20'd1;
            end
         end
         default: state_n = PWRUP;
      endcase
   end

   // EN is registered from the next state so a reset edge cuts a pulse immediately.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= PWRUP;
         cnt        <= PWRUP_LD;
         init_idx   <= 3'd0;
         o_lcd_en   <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_data <= 8'h00;
         o_lcd_on   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         init_idx <= init_idx_n;
         o_lcd_en <= (state_n == EN_HI);
         o_lcd_on <= i_on;
         if (load) begin
            {o_lcd_rs, o_lcd_data} <= load_byte;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
         o_drop   <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {wr.i_wr_rs, wr.i_wr_data};
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + 3'd1;
         end else if (pop && !push) begin
            fifo_cnt <= fifo_cnt - 3'd1;
         end
         // A refused push is remembered even when a pop frees space this cycle.
         if (wr.i_wr_vld && !wr.o_wr_rdy) begin
            o_drop <= 1'b1;
         end
      end
   end

endmodule
